// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM access controller and its bank ports.
package sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    R_SETUP,
    R_WAIT,
    R_SAMPLE
  } state_e;

  localparam logic STROBE_ON    = 1'b0;
  localparam logic STROBE_OFF   = 1'b1;
  localparam int   BANK_SEL_BIT = 16;
  localparam int   RAM_ADDR_W   = 18;

  // Bank-independent strobe intents; the bank port gates them with its select.
  typedef struct packed {
    logic en;
    logic oe;
    logic we;
    logic drive;
  } intent_t;

  function automatic intent_t intent_for(state_e s);
    intent_t t;
    t = '0;
    case (s)
      W_SETUP, W_HOLD: begin
        t.en    = 1'b1;
        t.drive = 1'b1;
      end
      W_PULSE: begin
        t.en    = 1'b1;
        t.we    = 1'b1;
        t.drive = 1'b1;
      end
      R_SETUP, R_WAIT, R_SAMPLE: begin
        t.en = 1'b1;
        t.oe = 1'b1;
      end
      default: t = '0;
    endcase
    return t;
  endfunction

  function automatic logic [RAM_ADDR_W-1:0] zext_addr(logic [15:0] a);
    return {2'b00, a};
  endfunction

endpackage

// File: rtl/sram_bank_port.sv
// One external SRAM bank: turns shared intents into active-low strobes and a tri-state bus.
module sram_bank_port
  import sram_pkg::*;
(
  input  logic                  sel_i,
  input  logic                  en_i,
  input  logic                  oe_i,
  input  logic                  we_i,
  input  logic                  drive_i,
  input  logic [RAM_ADDR_W-1:0] addr_i,
  input  logic [15:0]           wdata_i,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic                  ram_en_o,
  output logic                  ram_oe_o,
  output logic                  ram_we_o,
  inout  wire  [15:0]           ram_data_io,
  output logic [15:0]           rdata_o
);

  assign ram_addr_o = addr_i;
  assign ram_en_o   = (sel_i && en_i)        ? STROBE_ON : STROBE_OFF;
  assign ram_oe_o   = (sel_i && en_i && oe_i) ? STROBE_ON : STROBE_OFF;
  assign ram_we_o   = (sel_i && en_i && we_i) ? STROBE_ON : STROBE_OFF;

  // Never drive while the SRAM may be driving back (OE intent active).
  assign ram_data_io = (sel_i && drive_i && !oe_i) ? wdata_i : 16'hzzzz;
  assign rdata_o     = ram_data_io;

endmodule

// File: rtl/sram_access_ctrl.sv
// Single-word read/write responder for two asynchronous SRAM banks.
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int WR_PULSE_CYC = 2,
  parameter int RD_WAIT_CYC  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  re_i,
  input  logic                  we_i,
  input  logic [16:0]           addr_i,
  input  logic [15:0]           data_in_i,
  output logic [15:0]           data_out_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic [RAM_ADDR_W-1:0] ram_addr1_o,
  output logic [RAM_ADDR_W-1:0] ram_addr2_o,
  inout  wire  [15:0]           ram_data1_io,
  inout  wire  [15:0]           ram_data2_io,
  output logic                  ram1_en_o,
  output logic                  ram2_en_o,
  output logic                  ram1_oe_o,
  output logic                  ram2_oe_o,
  output logic                  ram1_we_o,
  output logic                  ram2_we_o
);

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  intent_t               ctrl_q;
  logic                  bank_q;
  logic [15:0]           wdata_q;
  logic [RAM_ADDR_W-1:0] addr1_q, addr2_q;
  logic                  re_q, we_q;
  logic                  done_q, busy_q;
  logic [15:0]           data_out_q;
  logic [15:0]           rdata1, rdata2;
  logic                  rd_edge, wr_edge, accept;

  assign rd_edge = re_i && !re_q;
  assign wr_edge = we_i && !we_q;
  assign accept  = en_i && (state_q == IDLE) && (rd_edge || wr_edge);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // A write edge wins over a simultaneous read edge.
          if (wr_edge)      state_d = W_SETUP;
          else if (rd_edge) state_d = R_SETUP;
        end
        W_SETUP: begin
          state_d = W_PULSE;
          cnt_d   = 16'(WR_PULSE_CYC - 1);
        end
        W_PULSE: begin
          if (cnt_q == '0) state_d = W_HOLD;
          else             cnt_d   = cnt_q - 16'd1;
        end
        W_HOLD: state_d = IDLE;
        R_SETUP: begin
          state_d = R_WAIT;
          cnt_d   = 16'(RD_WAIT_CYC - 1);
        end
        R_WAIT: begin
          if (cnt_q == '0) state_d = R_SAMPLE;
          else             cnt_d   = cnt_q - 16'd1;
        end
        R_SAMPLE: state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      bank_q     <= 1'b0;
      wdata_q    <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      re_q    <= re_i;
      we_q    <= we_i;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= intent_for(state_d);
      busy_q  <= (state_d != IDLE);
      done_q  <= en_i && ((state_q == W_HOLD) || (state_q == R_SAMPLE));
      if (accept) begin
        bank_q  <= addr_i[BANK_SEL_BIT];
        wdata_q <= data_in_i;
        if (addr_i[BANK_SEL_BIT]) addr2_q <= zext_addr(addr_i[15:0]);
        else                      addr1_q <= zext_addr(addr_i[15:0]);
      end
      if (en_i && (state_q == R_SAMPLE))
        data_out_q <= bank_q ? rdata2 : rdata1;
    end
  end

  sram_bank_port u_bank1 (
    .sel_i       (!bank_q),
    .en_i        (ctrl_q.en),
    .oe_i        (ctrl_q.oe),
    .we_i        (ctrl_q.we),
    .drive_i     (ctrl_q.drive),
    .addr_i      (addr1_q),
    .wdata_i     (wdata_q),
    .ram_addr_o  (ram_addr1_o),
    .ram_en_o    (ram1_en_o),
    .ram_oe_o    (ram1_oe_o),
    .ram_we_o    (ram1_we_o),
    .ram_data_io (ram_data1_io),
    .rdata_o     (rdata1)
  );

  sram_bank_port u_bank2 (
    .sel_i       (bank_q),
    .en_i        (ctrl_q.en),
    .oe_i        (ctrl_q.oe),
    .we_i        (ctrl_q.we),
    .drive_i     (ctrl_q.drive),
    .addr_i      (addr2_q),
    .wdata_i     (wdata_q),
    .ram_addr_o  (ram_addr2_o),
    .ram_en_o    (ram2_en_o),
    .ram_oe_o    (ram2_oe_o),
    .ram_we_o    (ram2_we_o),
    .ram_data_io (ram_data2_io),
    .rdata_o     (rdata2)
  );

  assign data_out_o = data_out_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: behavioural SRAM banks, memory scoreboard, directed and random ops.
module tb_sram_access_ctrl;

  localparam int WR = 2;
  localparam int RD = 2;

  logic        clk = 1'b0;
  logic        rst, en, re, we;
  logic [16:0] addr;
  logic [15:0] data_in, data_out;
  logic        done, busy;
  logic [17:0] ram_addr1, ram_addr2;
  wire  [15:0] ram_data1, ram_data2;
  logic        ram1_en, ram2_en, ram1_oe, ram2_oe, ram1_we, ram2_we;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int mon_viol = 0;

  logic [15:0] mem1 [0:65535];
  logic [15:0] mem2 [0:65535];
  logic [15:0] ref_mem [logic [16:0]];

  sram_access_ctrl #(.WR_PULSE_CYC(WR), .RD_WAIT_CYC(RD)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .re_i(re), .we_i(we),
    .addr_i(addr), .data_in_i(data_in), .data_out_o(data_out),
    .done_o(done), .busy_o(busy),
    .ram_addr1_o(ram_addr1), .ram_addr2_o(ram_addr2),
    .ram_data1_io(ram_data1), .ram_data2_io(ram_data2),
    .ram1_en_o(ram1_en), .ram2_en_o(ram2_en),
    .ram1_oe_o(ram1_oe), .ram2_oe_o(ram2_oe),
    .ram1_we_o(ram1_we), .ram2_we_o(ram2_we)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM behaviour: drive on EN&OE, store while EN&WE are low.
  assign ram_data1 = (!ram1_en && !ram1_oe) ? mem1[ram_addr1[15:0]] : 16'hzzzz;
  assign ram_data2 = (!ram2_en && !ram2_oe) ? mem2[ram_addr2[15:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ram1_en && !ram1_we) mem1[ram_addr1[15:0]] = ram_data1;
    if (!ram2_en && !ram2_we) mem2[ram_addr2[15:0]] = ram_data2;
  end

  always begin
    @(posedge clk);
    #2;
    if (done) done_cnt++;
    if ((!ram1_en && !ram2_en) || (!ram1_oe && !ram1_we) || (!ram2_oe && !ram2_we) ||
        (!ram1_oe && ram1_en) || (!ram2_oe && ram2_en) || (done && busy))
      mon_viol++;
  end

  function automatic logic [15:0] init_val(logic [16:0] a);
    return a[16] ? (a[15:0] ^ 16'hC3C3) : (a[15:0] ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] ref_read(logic [16:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for done; checks bank selection each busy cycle.
  task automatic do_op(input bit wr, input logic [16:0] a, input logic [15:0] d,
                       output int lat, output bit sel_ok);
    logic sel_en, oth_en;
    logic [17:0] sel_addr;
    @(negedge clk);
    addr = a;
    data_in = d;
    if (wr) we = 1'b1; else re = 1'b1;
    lat = -1;
    sel_ok = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      sel_en   = a[16] ? ram2_en : ram1_en;
      oth_en   = a[16] ? ram1_en : ram2_en;
      sel_addr = a[16] ? ram_addr2 : ram_addr1;
      if (sel_en !== 1'b0 || oth_en !== 1'b1 || sel_addr !== {2'b00, a[15:0]}) sel_ok = 1'b0;
    end
    we = 1'b0;
    re = 1'b0;
    if (wr) ref_mem[a] = d;
  endtask

  typedef struct {
    bit          wr;
    logic [16:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat, cnt_a, cnt_b, cnt_c, done_at, d0;
    bit ok, ok2, ok3;
    logic [15:0] exp_d;
    logic [16:0] ra;
    bit rw;

    for (int i = 0; i < 65536; i++) begin
      mem1[i] = init_val({1'b0, 16'(i)});
      mem2[i] = init_val({1'b1, 16'(i)});
    end
    for (int i = 0; i < 10; i++)
      vecs.push_back('{1'b1, 17'(i), 16'h0100 + 16'(i), 16'h0});
    for (int i = 0; i < 10; i++)
      vecs.push_back('{1'b0, 17'(i), 16'h0, 16'h0100 + 16'(i)});
    vecs.push_back('{1'b1, 17'h10003, 16'h1234, 16'h0});
    vecs.push_back('{1'b0, 17'h10003, 16'h0, 16'h1234});

    rst = 1'b0; en = 1'b1; re = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    repeat (3) @(negedge clk);
    check("reset_strobes", {ram1_en, ram2_en, ram1_oe, ram2_oe, ram1_we, ram2_we}, 6'h3F);
    check("reset_addr", {ram_addr1, ram_addr2}, 36'h0);
    check("reset_dout", data_out, 16'h0);
    check("reset_done_busy", {done, busy}, 2'b00);
    rst = 1'b1;

    // Detailed write timing to bank1
    @(negedge clk);
    addr = 17'h00012; data_in = 16'hA5A5; we = 1'b1;
    cnt_a = 0; cnt_b = 0; done_at = 0; ok = 1; ok2 = 1; ok3 = 1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!ram1_we) cnt_a++;
      if (busy) cnt_b++;
      if (done && done_at == 0) done_at = c;
      if (c <= 4 && ram_data1 !== 16'hA5A5) ok = 0;
      if (c <= 4 && ram_addr1 !== 18'h00012) ok3 = 0;
      if ({ram2_en, ram2_oe, ram2_we} !== 3'b111) ok2 = 0;
    end
    we = 1'b0;
    ref_mem[17'h00012] = 16'hA5A5;
    check("wr_we_low_cycles", cnt_a, WR);
    check("wr_busy_cycles", cnt_b, WR + 2);
    check("wr_done_cycle", done_at, WR + 3);
    check("wr_bus_data", ok, 1);
    check("wr_addr1", ok3, 1);
    check("wr_bank2_idle", ok2, 1);
    check("wr_mem_content", mem1[16'h0012], 16'hA5A5);

    // Detailed read back
    @(negedge clk);
    addr = 17'h00012; re = 1'b1;
    cnt_a = 0; done_at = 0; exp_d = 16'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!ram1_oe) cnt_a++;
      if (done && done_at == 0) begin
        done_at = c;
        exp_d = data_out;
      end
    end
    re = 1'b0;
    check("rd_oe_low_cycles", cnt_a, RD + 2);
    check("rd_done_cycle", done_at, RD + 3);
    check("rd_data_at_done", exp_d, 16'hA5A5);

    // Table: back-to-back writes/reads, then bank2
    d0 = done_cnt;
    foreach (vecs[i]) begin
      do_op(vecs[i].wr, vecs[i].a, vecs[i].d, lat, ok);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].wr ? WR + 3 : RD + 3);
      check($sformatf("vec%0d_bank_sel", i), ok, 1);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), data_out, vecs[i].exp);
      if (i == 19) check("b2b_done_count", done_cnt - d0, 20);
    end
    check("bank2_addr", ram_addr2, 18'h00003);
    check("bank1_addr_held", ram_addr1, 18'h00009);
    check("bank2_mem", mem2[16'h0003], 16'h1234);

    // Simultaneous re/we edges: a single write
    @(negedge clk);
    addr = 17'h00020; data_in = 16'hBEEF; re = 1'b1; we = 1'b1;
    d0 = done_cnt; cnt_a = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (!ram1_oe || !ram2_oe) cnt_a++;
    end
    re = 1'b0; we = 1'b0;
    ref_mem[17'h00020] = 16'hBEEF;
    check("collide_done_count", done_cnt - d0, 1);
    check("collide_no_read", cnt_a, 0);
    check("collide_mem", mem1[16'h0020], 16'hBEEF);

    // Second we edge while busy is ignored; write data was latched
    @(negedge clk);
    addr = 17'h00021; data_in = 16'h1111; we = 1'b1;
    d0 = done_cnt;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 2) we = 1'b0;
      if (c == 3) begin
        we = 1'b1;
        data_in = 16'h2222;
      end
    end
    we = 1'b0;
    ref_mem[17'h00021] = 16'h1111;
    check("busy_edge_done_count", done_cnt - d0, 1);
    check("busy_edge_mem", mem1[16'h0021], 16'h1111);

    // en dropped during W_PULSE
    @(negedge clk);
    addr = 17'h00022; data_in = 16'h3333; we = 1'b1;
    @(negedge clk);
    @(negedge clk);
    d0 = done_cnt;
    en = 1'b0;
    @(negedge clk);
    check("en_abort_strobes", {ram1_en, ram2_en, ram1_oe, ram2_oe, ram1_we, ram2_we}, 6'h3F);
    check("en_abort_busy_done", {busy, done}, 2'b00);
    repeat (6) @(negedge clk);
    check("en_abort_no_done", done_cnt - d0, 0);
    en = 1'b1; we = 1'b0;
    ref_mem.delete(17'h00022);

    // rst during R_WAIT
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst_pulse_dout", data_out, 16'h0);
    @(negedge clk);
    addr = 17'h00012; re = 1'b1;
    @(negedge clk);
    @(negedge clk);
    d0 = done_cnt;
    rst = 1'b0;
    @(negedge clk);
    check("rst_abort_strobes", {ram1_en, ram2_en, ram1_oe, ram2_oe, ram1_we, ram2_we}, 6'h3F);
    check("rst_abort_busy_done", {busy, done}, 2'b00);
    check("rst_abort_dout", data_out, 16'h0);
    rst = 1'b1; re = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_abort_no_done", done_cnt - d0, 0);
    do_op(1'b0, 17'h00012, 16'h0, lat, ok);
    check("recover_rdata", data_out, 16'hA5A5);

    // Random ops against the memory scoreboard
    for (int i = 0; i < 150; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = {1'($urandom_range(0, 1)), 16'h0040 + 16'($urandom_range(0, 15))};
      exp_d = ref_read(ra);
      do_op(rw, ra, 16'($urandom), lat, ok);
      if (lat != (rw ? WR + 3 : RD + 3) || !ok || (!rw && data_out !== exp_d))
        check($sformatf("rand%0d_op", i), {lat[7:0], 7'h0, ok, data_out},
              {8'(rw ? WR + 3 : RD + 3), 8'h01, rw ? data_out : exp_d});
      else
        n_tests++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("invariant_violations", mon_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
